// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner of the shared 8:1 mux select, with beat-count fairness and
// a valid/ready qualification of the mux output toward the downstream consumer.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;

  logic       owner_req;
  logic       beat;
  logic       limit_hit;
  logic [7:0] others;
  logic [2:0] win;

  // First set bit of r, scanning upward from last+1 and wrapping past 7.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
    logic [2:0] idx;
    rr_pick = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = last + 3'd1 + 3'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign owner_req = |(gnt_q & req);
  assign beat      = owner_req & out_ready;
  assign limit_hit = beat && (({1'b0, cnt_q} + 9'd1) == 9'(MAX_BEATS));
  assign others    = req & ~gnt_q;
  assign win       = rr_pick(others, last_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req != 8'd0) begin
          state_d = GRANT;
          gnt_d   = 8'd1 << win;
          sel_d   = win;
          last_d  = win;
          cnt_d   = 8'd0;
        end
      end
      GRANT: begin
        if (!owner_req || limit_hit) begin
          if (others != 8'd0) begin
            gnt_d  = 8'd1 << win;
            sel_d  = win;
            last_d = win;
            cnt_d  = 8'd0;
          end else if (owner_req) begin
            // Limit reached with nobody else waiting: keep the grant, restart the count.
            cnt_d = 8'd0;
          end else begin
            state_d = IDLE;
            gnt_d   = 8'd0;
            sel_d   = 3'd0;
            cnt_d   = 8'd0;
          end
        end else if (beat) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'd0;
        sel_d   = 3'd0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 8'd0;
      sel_q   <= 3'd0;
      last_q  <= 3'd7;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = (state_q == GRANT);
  assign out_valid = owner_req;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scenario bench for mux8_rr_arbiter: per-cycle expected grant/select/valid/busy
// are queued as stimulus is driven and compared at the following falling edge.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'd0;
  logic       out_ready = 1'b0;
  logic [7:0] gnt, gnt1;
  logic [2:0] sel, sel1;
  logic       out_valid, out_valid1;
  logic       busy, busy1;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.MAX_BEATS(4)) u_dut (
    .clk(clk), .reset(reset), .req(req), .out_ready(out_ready),
    .gnt(gnt), .sel(sel), .out_valid(out_valid), .busy(busy)
  );

  mux8_rr_arbiter #(.MAX_BEATS(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req), .out_ready(out_ready),
    .gnt(gnt1), .sel(sel1), .out_valid(out_valid1), .busy(busy1)
  );

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  exp_t got;
  int   compared = 0;
  int   mismatched = 0;

  function automatic exp_t mk(input logic [7:0] g, input logic v);
    exp_t r;
    r.gnt   = g;
    r.sel   = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) r.sel = 3'(i);
    r.valid = v;
    r.busy  = (g != 8'd0);
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1; req = 8'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(8'h00, 1'b0));
      @(negedge clk);
      e = exp_q.pop_front();
      got = '{gnt, sel, out_valid, busy};
      compared++;
      if (got !== e || gnt1 !== 8'h00) begin
        mismatched++;
        $display("FAIL reset k=%0d got gnt=%h sel=%0d v=%b busy=%b gnt1=%h want gnt=%h sel=%0d v=%b busy=%b",
                 k, gnt, sel, out_valid, busy, gnt1, e.gnt, e.sel, e.valid, e.busy);
      end else $display("ok reset k=%0d gnt=%h", k, gnt);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rotation();
    reset = 1'b0; req = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 36; k++) begin
      if (k == 0) exp_q.push_back(mk(8'h00, 1'b0));
      else        exp_q.push_back(mk(8'd1 << (((k - 1) / 4) % 8), 1'b1));
      @(negedge clk);
      e = exp_q.pop_front();
      got = '{gnt, sel, out_valid, busy};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL rotation k=%0d got gnt=%h sel=%0d v=%b busy=%b want gnt=%h sel=%0d v=%b busy=%b",
                 k, gnt, sel, out_valid, busy, e.gnt, e.sel, e.valid, e.busy);
      end else $display("ok rotation k=%0d gnt=%h sel=%0d", k, gnt, sel);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h20; out_ready = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      exp_q.push_back(k == 0 ? mk(8'h00, 1'b0) : mk(8'h20, 1'b1));
      @(negedge clk);
      e = exp_q.pop_front();
      got = '{gnt, sel, out_valid, busy};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL single k=%0d got gnt=%h sel=%0d v=%b busy=%b want gnt=%h sel=%0d v=%b busy=%b",
                 k, gnt, sel, out_valid, busy, e.gnt, e.sel, e.valid, e.busy);
      end else $display("ok single k=%0d gnt=%h sel=%0d", k, gnt, sel);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    logic [7:0] g;
    do_reset();
    req = 8'h09;
    for (int k = 0; k <= 18; k++) begin
      out_ready = (k % 2 == 0);
      if (k == 0)       g = 8'h00;
      else if (k <= 8)  g = 8'h01;
      else if (k <= 16) g = 8'h08;
      else              g = 8'h01;
      exp_q.push_back(mk(g, g != 8'h00));
      @(negedge clk);
      e = exp_q.pop_front();
      got = '{gnt, sel, out_valid, busy};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL stall k=%0d got gnt=%h sel=%0d v=%b busy=%b want gnt=%h sel=%0d v=%b busy=%b",
                 k, gnt, sel, out_valid, busy, e.gnt, e.sel, e.valid, e.busy);
      end else $display("ok stall k=%0d rdy=%b gnt=%h", k, out_ready, gnt);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_drop();
    logic [7:0] r_tab [6];
    exp_t       e_tab [6];
    r_tab = '{8'h44, 8'h44, 8'h40, 8'h40, 8'h00, 8'h00};
    e_tab = '{mk(8'h00, 1'b0), mk(8'h04, 1'b1), mk(8'h04, 1'b0),
              mk(8'h40, 1'b1), mk(8'h40, 1'b0), mk(8'h00, 1'b0)};
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req = r_tab[k];
      exp_q.push_back(e_tab[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      got = '{gnt, sel, out_valid, busy};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL drop k=%0d got gnt=%h sel=%0d v=%b busy=%b want gnt=%h sel=%0d v=%b busy=%b",
                 k, gnt, sel, out_valid, busy, e.gnt, e.sel, e.valid, e.busy);
      end else $display("ok drop k=%0d req=%h gnt=%h", k, req, gnt);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'h10;
    for (int k = 0; k <= 4; k++) begin
      out_ready = (k <= 3);
      exp_q.push_back(k == 0 ? mk(8'h00, 1'b0) : mk(8'h10, 1'b1));
      @(negedge clk);
      e = exp_q.pop_front();
      got = '{gnt, sel, out_valid, busy};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL midreset_pre k=%0d got gnt=%h v=%b busy=%b want gnt=%h v=%b busy=%b",
                 k, gnt, out_valid, busy, e.gnt, e.valid, e.busy);
      end else $display("ok midreset_pre k=%0d gnt=%h", k, gnt);
      if (k < 4) begin @(posedge clk); #1; end
    end
    #2 reset = 1'b1;
    exp_q.push_back(mk(8'h00, 1'b0));
    #1;
    e = exp_q.pop_front();
    got = '{gnt, sel, out_valid, busy};
    compared++;
    if (got !== e) begin
      mismatched++;
      $display("FAIL midreset_async got gnt=%h sel=%0d v=%b busy=%b want gnt=00 sel=0 v=0 busy=0",
               gnt, sel, out_valid, busy);
    end else $display("ok midreset_async gnt=%h", gnt);
    @(posedge clk); #1;
    reset = 1'b0; req = 8'h30; out_ready = 1'b1;
    for (int j = 0; j <= 5; j++) begin
      if (j == 0)      exp_q.push_back(mk(8'h00, 1'b0));
      else if (j <= 4) exp_q.push_back(mk(8'h10, 1'b1));
      else             exp_q.push_back(mk(8'h20, 1'b1));
      @(negedge clk);
      e = exp_q.pop_front();
      got = '{gnt, sel, out_valid, busy};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL midreset_post j=%0d got gnt=%h sel=%0d v=%b busy=%b want gnt=%h sel=%0d v=%b busy=%b",
                 j, gnt, sel, out_valid, busy, e.gnt, e.sel, e.valid, e.busy);
      end else $display("ok midreset_post j=%0d gnt=%h", j, gnt);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 8'h81; out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k == 0) exp_q.push_back(mk(8'h00, 1'b0));
      else        exp_q.push_back(mk((k % 2 == 1) ? 8'h01 : 8'h80, 1'b1));
      @(negedge clk);
      e = exp_q.pop_front();
      got = '{gnt1, sel1, out_valid1, busy1};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL b2b_max1 k=%0d got gnt=%h sel=%0d v=%b busy=%b want gnt=%h sel=%0d v=%b busy=%b",
                 k, gnt1, sel1, out_valid1, busy1, e.gnt, e.sel, e.valid, e.busy);
      end else $display("ok b2b_max1 k=%0d gnt=%h", k, gnt1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_rotation();
    test_single();
    test_stall();
    test_drop();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares the 8:1 select multiplexer between eight requesters. It owns the mux select lines: it picks one requester and drives the 3-bit select with that requester's index, so that requester's input reaches the shared output. It also qualifies the mux output with a valid/ready handshake toward the downstream consumer. Beat-count fairness stops one requester from holding the channel while others are waiting.

## Interface
- MAX_BEATS, default 4: accepted beats per grant before forced rotation; legal range 1..255.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  level request per requester; bit i asks for mux input i.
- out_ready  input  1  downstream accepts the current beat.
- gnt  output  8  registered one-hot grant; all zero when idle.
- sel  output  3  mux select, with sel[0], sel[1], sel[2] driving a0, a1, a2; equals the index of the granted requester; 0 when idle.
- out_valid  output  1  combinational, equals OR of (gnt & req).
- busy  output  1  high when any grant is active.

## Operation
- States:
  - IDLE: gnt = 0.
  - GRANT: exactly one gnt bit set.
- Reset values (asynchronous): gnt = 0, sel = 0, busy = 0, beat counter = 0, last_owner = 7, state = IDLE. out_valid is therefore 0.
  - Consequence: after reset, requester 0 has top priority.
- Round-robin pick: search req starting at (last_owner+1) mod 8 and wrap through index 7 back to 0. The first set bit wins. On every grant, last_owner is set to the winner.
- IDLE -> GRANT: at any edge where req != 0. The counter clears.
- A beat is any cycle with out_valid=1 and out_ready=1. Each beat increments the 8-bit counter.
- GRANT, owner drops req: at the next edge the grant is re-evaluated.
  - If other requests are pending, the new round-robin winner is granted and the counter clears.
  - Otherwise the block returns to IDLE.
  - The old owner's gnt stays high for the cycle in which req fell. out_valid is 0 in that cycle.
- GRANT, MAX_BEATS-th beat accepted:
  - If any other req bit is high in that cycle, the grant moves to the next round-robin winner at that edge.
  - If not, the counter clears and the owner keeps the grant with no bubble.
- Owner drop and limit reached in the same cycle: both conditions produce the same result (rotate, or go to IDLE if no one else is requesting).
- A requester that re-raises req after being rotated away waits its round-robin turn. It is not granted again until every other pending requester has been served once.
- No combinational path from req or out_ready to gnt or sel. Only out_valid is combinational.
- Reset asserted mid-grant: everything returns to the reset values immediately. No beat is counted in that cycle.

## Timing
- Grant latency: req rises in cycle n while IDLE -> gnt and sel valid in cycle n+1, with out_valid=1 in n+1 if req is still high.
- Back-to-back handover: the new owner's gnt is valid the cycle after the rotating edge, with zero idle cycles between owners when others are pending.
- Release latency: owner drops req in cycle n -> gnt changes in cycle n+1. Exactly one cycle with out_valid=0.
- Maximum wait for any continuously requesting input: 7 × MAX_BEATS accepted beats plus 7 handover cycles, provided out_ready keeps toggling.
- out_ready=0 stalls: the counter holds, the grant holds, and no timeout applies.
- The mux output path to downstream is combinational through sel. Downstream samples it on edges where out_valid & out_ready = 1.

## Test plan
- Reset with req=8'hFF, release reset, out_ready=1 -> gnt=8'h01 and sel=0 one cycle later; after 4 beats gnt=8'h02 and sel=1; then 8'h04, continuing through to 8'h80 and wrapping to 8'h01.
- Single requester req=8'h20, out_ready=1 for 20 cycles -> gnt stays 8'h20 and sel=5 throughout; the counter wraps every 4 beats with no bubble; busy=1.
- req=8'h09 (inputs 0 and 3), out_ready toggling 1,0,1,0 -> input 0 holds the grant for 8 cycles (4 beats), then gnt=8'h08; the counter holds during out_ready=0 cycles.
- Owner 2 drops req in cycle n while req[6]=1 -> cycle n has out_valid=0 with gnt=8'h04; cycle n+1 has gnt=8'h40 and sel=6.
- Assert reset while gnt=8'h10 and counter=3 -> gnt=0, sel=0, busy=0 immediately with no clock edge; with req=8'h10 still high after release, gnt=8'h10 follows one cycle later.
- MAX_BEATS=1, req=8'h81 -> the grant alternates 8'h01, 8'h80, 8'h01, … every accepted beat, with no idle cycles.
